// File: rtl/multu_hilo_unit.sv
// Iterative radix-2 unsigned multiplier with HI/LO result registers.
// Serves MULTU, MFHI and MFLO, and stalls the datapath while a product is in flight.
module multu_hilo_unit #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_srca,
   input  logic [WIDTH-1:0] i_srcb,
   input  logic             i_rd_req,
   input  logic             i_rd_hi,
   output logic [WIDTH-1:0] o_rdata,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_stall
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t               r_state;
   state_t               w_stateNext;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   w_accNext;
   logic [WIDTH-1:0]     r_mplier;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic [CW-1:0]        r_count;
   logic                 r_done;
   logic                 w_accept;
   logic                 w_finish;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // A start arriving while RUN is deliberately not accepted; the stalled datapath re-presents it.
   always_comb begin
      w_stateNext = r_state;
      w_accept    = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_accept    = 1'b1;
               w_stateNext = RUN;
            end
         end
         RUN: begin
            if (r_count == CW'(1)) begin
               w_finish    = 1'b1;
               w_stateNext = IDLE;
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   assign w_accNext = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_count  <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_srca};
            r_mplier <= i_srcb;
            r_acc    <= '0;
            r_count  <= COUNT_INIT;
         end else if (r_state == RUN) begin
            r_acc    <= w_accNext;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - CW'(1);
            // The last partial product is folded in directly so HI/LO land on the same edge.
            if (w_finish) begin
               {r_hi, r_lo} <= w_accNext;
               r_done       <= 1'b1;
            end
         end
      end
   end

   assign o_hi    = r_hi;
   assign o_lo    = r_lo;
   assign o_busy  = (r_state == RUN);
   assign o_done  = r_done;
   assign o_stall = o_busy & (i_start | i_rd_req);
   assign o_rdata = i_rd_hi ? r_hi : r_lo;

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Directed self-checking bench for multu_hilo_unit: latency, HI/LO results, stall and read-before-write.
module tb_multu_hilo_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic        rdReq;
   logic        rdHi;
   logic [31:0] rdata;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        stall;

   int numCompared   = 0;
   int numMismatched = 0;

   multu_hilo_unit #(.WIDTH(32)) dut (
      .i_clk    (clk),
      .i_reset  (reset),
      .i_start  (start),
      .i_srca   (srcA),
      .i_srcb   (srcB),
      .i_rd_req (rdReq),
      .i_rd_hi  (rdHi),
      .o_rdata  (rdata),
      .o_hi     (hi),
      .o_lo     (lo),
      .o_busy   (busy),
      .o_done   (done),
      .o_stall  (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point; every check is counted here.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      numCompared++;
      if (observed !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives the inputs and lets the combinational outputs settle.
   task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                                input logic rq, input logic rh);
      start = s;
      srcA  = a;
      srcB  = b;
      rdReq = rq;
      rdHi  = rh;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues a multiply from idle and checks latency, the done pulse and the product.
   task automatic runMult(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expHi, input logic [31:0] expLo);
      int busyCnt;
      int doneInBusy;
      applyStimulus(1'b1, a, b, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      busyCnt    = 0;
      doneInBusy = 0;
      while (busy && busyCnt < 100) begin
         if (done) doneInBusy++;
         busyCnt++;
         step();
      end
      checkOutput({tag, "_busyCycles"}, 64'(busyCnt), 64'd32);
      checkOutput({tag, "_doneWhileBusy"}, 64'(doneInBusy), 64'd0);
      checkOutput({tag, "_done"}, 64'(done), 64'd1);
      checkOutput({tag, "_hi"}, 64'(hi), 64'(expHi));
      checkOutput({tag, "_lo"}, 64'(lo), 64'(expLo));
   endtask

   initial begin
      int busyCnt;
      int stallCnt;

      reset = 1'b1;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      reset = 1'b0;
      #1;
      checkOutput("rst_hi", 64'(hi), 64'd0);
      checkOutput("rst_lo", 64'(lo), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("rst_rdata", 64'(rdata), 64'd0);
      checkOutput("rst_stall", 64'(stall), 64'd0);

      // 3 * 5 = 0xF
      runMult("basic", 32'd3, 32'd5, 32'h0, 32'h0000000F);
      step();
      checkOutput("basic_doneDrop", 64'(done), 64'd0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("mflo_rdata", 64'(rdata), 64'h0000000F);
      checkOutput("mflo_stall", 64'(stall), 64'd0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      checkOutput("mfhi_rdata", 64'(rdata), 64'h0);

      // 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001 ; 0x80000000*2 = 0x1_00000000
      runMult("max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      runMult("msb", 32'h80000000, 32'd2, 32'h00000001, 32'h00000000);

      // 0x10000 * 0x10000 = 0x1_00000000, with MFHI held throughout
      applyStimulus(1'b1, 32'h00010000, 32'h00010000, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      busyCnt  = 0;
      stallCnt = 0;
      while (busy && busyCnt < 100) begin
         if (stall) stallCnt++;
         busyCnt++;
         step();
      end
      checkOutput("rdBusy_busyCycles", 64'(busyCnt), 64'd32);
      checkOutput("rdBusy_stallCycles", 64'(stallCnt), 64'd32);
      checkOutput("rdBusy_doneStall", 64'(stall), 64'd0);
      checkOutput("rdBusy_rdata", 64'(rdata), 64'h00000001);
      checkOutput("rdBusy_lo", 64'(lo), 64'h0);
      step();

      // 9*9 = 81 runs while a second start (7,6) is held; it must wait for the done cycle.
      applyStimulus(1'b1, 32'd9, 32'd9, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 32'd7, 32'd6, 1'b0, 1'b0);
      busyCnt  = 0;
      stallCnt = 0;
      while (busy && busyCnt < 100) begin
         if (stall) stallCnt++;
         busyCnt++;
         step();
      end
      checkOutput("b2b_stallCycles", 64'(stallCnt), 64'd32);
      checkOutput("b2b_firstLo", 64'(lo), 64'd81);
      checkOutput("b2b_firstHi", 64'(hi), 64'd0);
      checkOutput("b2b_doneStall", 64'(stall), 64'd0);
      step();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("b2b_accepted", 64'(busy), 64'd1);
      busyCnt = 0;
      while (busy && busyCnt < 100) begin
         busyCnt++;
         step();
      end
      checkOutput("b2b_secondBusy", 64'(busyCnt), 64'd32);
      checkOutput("b2b_secondLo", 64'(lo), 64'd42);

      // Start plus MFLO in one idle cycle reads the old LO; 5*5 = 25 follows.
      applyStimulus(1'b1, 32'd5, 32'd5, 1'b1, 1'b0);
      checkOutput("simul_rdata", 64'(rdata), 64'd42);
      checkOutput("simul_stall", 64'(stall), 64'd0);
      step();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("simul_loHeld", 64'(lo), 64'd42);
      busyCnt = 0;
      while (busy && busyCnt < 100) begin
         busyCnt++;
         step();
      end
      checkOutput("simul_lo", 64'(lo), 64'd25);

      // Reset in busy cycle 10 of 0xFFFFFFFF*2 aborts and clears HI/LO.
      applyStimulus(1'b1, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) step();
      checkOutput("midRst_busyBefore", 64'(busy), 64'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      checkOutput("midRst_busy", 64'(busy), 64'd0);
      checkOutput("midRst_done", 64'(done), 64'd0);
      checkOutput("midRst_hi", 64'(hi), 64'd0);
      checkOutput("midRst_lo", 64'(lo), 64'd0);
      runMult("afterRst", 32'd2, 32'd2, 32'h0, 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule

// File: doc/multu_hilo_unit.md
Name: multu_hilo_unit

Overview:
- Iterative unsigned multiplier with HI/LO result registers, downstream of the instruction decoder.
- Executes MULTU (R-type, funct 011001) and serves MFHI (funct 010000) and MFLO (funct 010010).
- Radix-2 shift-add, one bit per cycle, fixed latency.
- Asserts a stall to the datapath while a result is not yet available or the unit cannot accept a new multiply.

Parameters:
WIDTH, 32, operand width; HI and LO are WIDTH bits each; latency is WIDTH cycles.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  MULTU issued this cycle (decoded op 000000, funct 011001)
srca  input  WIDTH  multiplicand (rs value)
srcb  input  WIDTH  multiplier (rt value)
rd_req  input  1  MFHI or MFLO issued this cycle
rd_hi  input  1  1 = read HI (MFHI), 0 = read LO (MFLO); only valid with rd_req
rdata  output  WIDTH  rd_hi ? hi : lo, combinational from registers
hi  output  WIDTH  upper half of last completed product
lo  output  WIDTH  lower half of last completed product
busy  output  1  multiply in progress
done  output  1  one-cycle pulse on the cycle hi/lo take the new product
stall  output  1  freeze PC/pipeline this cycle

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is synchronous, active-high, and takes priority over everything else.
  - Reset values: hi=0, lo=0, busy=0, done=0, internal counter=0, accumulator=0, operand registers=0.
  - Reset mid-operation aborts the multiply. hi/lo are cleared, not partially updated.
- States:
  - IDLE (busy=0) and RUN (busy=1). A small internal counter (ceil(log2(WIDTH+1)) bits) tracks progress.
- IDLE:
  - Accept when start=1. Latch srca into multiplicand register (zero-extended to 2*WIDTH), srcb into multiplier register. Clear accumulator, set counter=WIDTH, go to RUN.
  - hi/lo are not changed on the accept cycle.
- RUN, each cycle:
  - If multiplier LSB=1, accumulator += multiplicand (2*WIDTH-bit add, no overflow is possible).
  - Shift multiplicand left by 1, shift multiplier right by 1, counter -= 1.
- RUN, cycle where counter==1:
  - Final step. {hi,lo} <= final accumulator value; done=1 for that following cycle; go to IDLE (busy=0 next cycle).
- Latency:
  - Start accepted at edge N; busy=1 from N+1 through N+WIDTH.
  - hi/lo hold the new product and done=1 in the cycle after edge N+WIDTH.
  - Back-to-back MULTU may be accepted in that same cycle.
- Timing is fixed: no early termination on zero operands.
- stall = busy & (start | rd_req), combinational.
  - start while busy is ignored by the unit; the stalled datapath re-presents it until accepted.
  - rd_req while busy stalls; rdata is don't-care while stall=1.
- rd_req while idle: rdata returns current hi/lo the same cycle; no stall.
- start and rd_req in the same idle cycle: start is accepted, and rdata returns the OLD hi/lo (read-before-write).
- Operands are unsigned. Product = srca*srcb exactly, 2*WIDTH bits; no sign handling.
- rd_hi is ignored when rd_req=0. rdata is always driven (mux of hi/lo).
- No other instruction affects hi/lo (MTHI/MTLO are not supported).

Test Plan:
- Reset then idle read:
  - reset=1 one cycle, then rd_req=1 rd_hi=0 -> rdata=0x00000000, stall=0, busy=0.
- Basic multiply:
  - start with srca=3, srcb=5 -> busy=1 for exactly 32 cycles, done pulses once, hi=0x00000000, lo=0x0000000F.
  - MFLO after completion -> rdata=0x0000000F, stall=0.
- Max operands:
  - srca=srcb=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 32 busy cycles.
  - srca=0x80000000, srcb=2 -> hi=0x00000001, lo=0x00000000.
- Read during busy:
  - start (0x10000, 0x10000), then rd_req=1 rd_hi=1 held each cycle -> stall=1 every busy cycle.
  - On the done cycle stall=0 and rdata=0x00000001 (lo=0x00000000).
- Back-to-back and simultaneity:
  - Second start (7,6) asserted while busy -> stall=1 and operands are not latched.
  - The second start is accepted in the done cycle -> lo=42 after 32 more cycles.
  - Idle start and rd_req in the same cycle -> rdata shows the old lo.
- Reset mid-operation:
  - reset asserted at busy cycle 10 of 0xFFFFFFFF*2 -> next cycle busy=0, done=0, hi=lo=0.
  - A subsequent multiply of 2*2 gives lo=4.
